// File: rtl/vex_bus_fabric_if.sv
// ---------------------------------------------------------------------------
// vex_bus_fabric_if
// Bundles the VexRiscv iBus/dBus handshakes and the MMIO slave-side signals
// that the bus fabric sits between.
//   slave  modport : the fabric's view (takes CPU commands and slave acks,
//                    drives CPU responses and slave selects)
//   master modport : the environment's view (CPU plus peripherals)
// Handshake rules:
//   ibus: a fetch transfers in a cycle with ibus_cmd_valid && ibus_cmd_ready;
//         ibus_rsp_valid follows exactly one cycle later.
//   dbus: the CPU holds dbus_cmd_* stable from valid until ready. A read
//         returns dbus_rsp_ready exactly one cycle after the ready cycle.
//         Writes complete on ready and produce no response.
//   slv : slv_cs[i] stays high until slv_ack[i] or a timeout; slv_rdata
//         is only meaningful while the matching ack is high.
// ---------------------------------------------------------------------------
interface vex_bus_fabric_if #(
  parameter int N_SLV     = 4,
  parameter int SLV_SHIFT = 8
);
  logic                   ibus_cmd_valid;
  logic                   ibus_cmd_ready;
  logic [31:0]            ibus_cmd_pc;
  logic                   ibus_rsp_valid;
  logic [31:0]            ibus_rsp_inst;

  logic                   dbus_cmd_valid;
  logic                   dbus_cmd_ready;
  logic                   dbus_cmd_wr;
  logic [31:0]            dbus_cmd_a;
  logic [31:0]            dbus_cmd_data;
  logic [1:0]             dbus_cmd_size;
  logic                   dbus_rsp_ready;
  logic [31:0]            dbus_rsp_data;
  logic                   dbus_rsp_error;

  logic [N_SLV-1:0]       slv_cs;
  logic                   slv_wr;
  logic [SLV_SHIFT-1:0]   slv_addr;
  logic [31:0]            slv_wdata;
  logic [3:0]             slv_be;
  logic [N_SLV*32-1:0]    slv_rdata;
  logic [N_SLV-1:0]       slv_ack;

  logic                   bus_err;

  modport slave (
    input  ibus_cmd_valid, ibus_cmd_pc,
    output ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_inst,
    input  dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_a, dbus_cmd_data, dbus_cmd_size,
    output dbus_cmd_ready, dbus_rsp_ready, dbus_rsp_data, dbus_rsp_error,
    output slv_cs, slv_wr, slv_addr, slv_wdata, slv_be,
    input  slv_rdata, slv_ack,
    output bus_err
  );

  modport master (
    output ibus_cmd_valid, ibus_cmd_pc,
    input  ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_inst,
    output dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_a, dbus_cmd_data, dbus_cmd_size,
    input  dbus_cmd_ready, dbus_rsp_ready, dbus_rsp_data, dbus_rsp_error,
    input  slv_cs, slv_wr, slv_addr, slv_wdata, slv_be,
    output slv_rdata, slv_ack,
    input  bus_err
  );
endinterface

// File: rtl/vex_bus_fabric.sv
// ---------------------------------------------------------------------------
// vex_bus_fabric
// iBus/dBus interconnect for the VexRiscv SoC: on-chip block RAM plus N_SLV
// MMIO slave windows, with multi-cycle slave handshakes, a slave timeout,
// error responses for unmapped/timed-out accesses and an ibus anti-starvation
// grant.
// Ports:
//   clk        system clock
//   resetn     synchronous reset, active low (RAM contents are kept)
//   bus        vex_bus_fabric_if.slave: CPU ibus/dbus + MMIO slave signals
//   dbg_state  current transaction FSM state (0 = IDLE, 1 = SLV)
// ---------------------------------------------------------------------------
module vex_bus_fabric #(
  parameter int         RAM_WORDS  = 16384,
  parameter int         N_SLV      = 4,
  parameter logic [7:0] MMIO_BASE  = 8'h02,
  parameter int         SLV_SHIFT  = 8,
  parameter int         TIMEOUT    = 255,
  parameter int         STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              resetn,
  vex_bus_fabric_if.slave   bus,
  output logic              dbg_state
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_IDLE = 1'b0, S_SLV = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            ibus_rsp_q, ibus_rsp_d;
  logic            rsp_ready_q, rsp_ready_d;
  logic            rsp_ram_q, rsp_ram_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     ram_rdata_q;

  logic            is_mmio, mapped, starve_hit, grant_d, ibus_grant;
  logic [3:0]      cmd_idx, cs_idx, be;
  logic [15:0]     ack_pad;
  logic [31:0]     sel_rdata;
  logic            dbus_ready, cs_hot, done_mmio, done_err, timeout_hit;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic            unused_bits;

  logic [31:0]     mem [RAM_WORDS];

  assign is_mmio    = (bus.dbus_cmd_a[31:24] == MMIO_BASE);
  assign cmd_idx    = bus.dbus_cmd_a[SLV_SHIFT +: 4];
  assign mapped     = ({1'b0, cmd_idx} < 5'(N_SLV));
  // Padding lets a 4-bit slave index address the ack vector for any N_SLV.
  assign ack_pad    = 16'(bus.slv_ack);
  // When ibus has waited STARVE_MAX dbus grants, it takes the next cycle.
  assign starve_hit = (starve_q == SW'(STARVE_MAX)) && bus.ibus_cmd_valid;
  assign grant_d    = (state_q == S_IDLE) && bus.dbus_cmd_valid && !starve_hit;
  assign ibus_grant = (state_q == S_IDLE) && bus.ibus_cmd_valid && !grant_d;
  assign unused_bits = ^{bus.ibus_cmd_pc, bus.dbus_cmd_a};

  // Byte strobes; the CPU already replicates write data across lanes.
  always_comb begin
    be = 4'b0000;
    if (bus.dbus_cmd_wr) begin
      case (bus.dbus_cmd_size)
        2'd0:    be = 4'b0001 << bus.dbus_cmd_a[1:0];
        2'd1:    be = 4'b0011 << bus.dbus_cmd_a[1:0];
        default: be = 4'b1111 << bus.dbus_cmd_a[1:0];
      endcase
    end
  end

  // Single-port RAM: the granted dbus access owns the port, else ibus fetch.
  assign ram_addr = grant_d ? bus.dbus_cmd_a[AW+1:2] : bus.ibus_cmd_pc[AW+1:2];
  assign ram_we   = grant_d && !is_mmio && bus.dbus_cmd_wr;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && be[i]) mem[ram_addr][8*i +: 8] <= bus.dbus_cmd_data[8*i +: 8];
    end
    ram_rdata_q <= mem[ram_addr];
  end

  always_comb begin
    starve_d = starve_q;
    if (ibus_grant || !bus.ibus_cmd_valid) starve_d = '0;
    else if (grant_d && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
  end

  // Transaction FSM: IDLE handles RAM/unmapped/zero-wait slaves in one cycle;
  // SLV waits for the latched slave's ack or the timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dbus_ready  = 1'b0;
    cs_hot      = 1'b0;
    cs_idx      = idx_q;
    done_mmio   = 1'b0;
    done_err    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          if (!is_mmio) begin
            dbus_ready = 1'b1;
          end else if (!mapped) begin
            dbus_ready = 1'b1;
            done_err   = 1'b1;
          end else begin
            cs_hot = 1'b1;
            cs_idx = cmd_idx;
            idx_d  = cmd_idx;
            if (ack_pad[cmd_idx]) begin
              dbus_ready = 1'b1;
              done_mmio  = 1'b1;
            end else begin
              state_d = S_SLV;
              cnt_d   = CW'(1);
            end
          end
        end
      end
      S_SLV: begin
        // An ack arriving in the timeout cycle still completes normally.
        if (ack_pad[idx_q]) begin
          cs_hot     = 1'b1;
          dbus_ready = 1'b1;
          done_mmio  = 1'b1;
          state_d    = S_IDLE;
          cnt_d      = '0;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          dbus_ready  = 1'b1;
          done_err    = 1'b1;
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end else begin
          cs_hot = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (cs_idx == 4'(i)) sel_rdata = bus.slv_rdata[32*i +: 32];
    end
  end

  always_comb begin
    ibus_rsp_d  = ibus_grant;
    rsp_ready_d = dbus_ready && !bus.dbus_cmd_wr;
    rsp_ram_d   = !is_mmio;
    rsp_err_d   = done_err && !bus.dbus_cmd_wr;
    bus_err_d   = done_err;
    rsp_data_d  = 32'h0;
    if (done_mmio)        rsp_data_d = sel_rdata;
    else if (timeout_hit) rsp_data_d = 32'hDEAD_BEEF;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      starve_q    <= '0;
      ibus_rsp_q  <= 1'b0;
      rsp_ready_q <= 1'b0;
      rsp_ram_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      starve_q    <= starve_d;
      ibus_rsp_q  <= ibus_rsp_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_ram_q   <= rsp_ram_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    bus.slv_cs = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (cs_hot && cs_idx == 4'(i)) bus.slv_cs[i] = 1'b1;
    end
  end

  assign bus.slv_wr         = cs_hot && bus.dbus_cmd_wr;
  assign bus.slv_addr       = cs_hot ? bus.dbus_cmd_a[SLV_SHIFT-1:0] : '0;
  assign bus.slv_wdata      = cs_hot ? bus.dbus_cmd_data : 32'h0;
  assign bus.slv_be         = cs_hot ? be : 4'b0000;
  assign bus.ibus_cmd_ready = ibus_grant;
  assign bus.ibus_rsp_valid = ibus_rsp_q;
  assign bus.ibus_rsp_inst  = ibus_rsp_q ? ram_rdata_q : 32'h0;
  assign bus.dbus_cmd_ready = dbus_ready;
  assign bus.dbus_rsp_ready = rsp_ready_q;
  assign bus.dbus_rsp_data  = !rsp_ready_q ? 32'h0 : (rsp_ram_q ? ram_rdata_q : rsp_data_q);
  assign bus.dbus_rsp_error = rsp_err_q;
  assign bus.bus_err        = bus_err_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_vex_bus_fabric.sv
// ---------------------------------------------------------------------------
// tb_vex_bus_fabric
// Directed bench for vex_bus_fabric: reset state, RAM byte/half writes and
// aliasing, ibus anti-starvation, multi-cycle and zero-wait slaves, slave
// timeout, unmapped accesses and reset while a slave access is pending.
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_vex_bus_fabric;
  logic clk = 1'b0;
  logic resetn;
  logic dbg_state;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_q[$];

  vex_bus_fabric_if #(.N_SLV(4), .SLV_SHIFT(8)) bus ();

  vex_bus_fabric #(
    .RAM_WORDS(16384), .N_SLV(4), .MMIO_BASE(8'h02), .SLV_SHIFT(8),
    .TIMEOUT(255), .STARVE_MAX(15)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic dbus_set(input logic v, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz);
    bus.dbus_cmd_valid = v;
    bus.dbus_cmd_wr    = wr;
    bus.dbus_cmd_a     = a;
    bus.dbus_cmd_data  = d;
    bus.dbus_cmd_size  = sz;
  endtask

  task automatic drive_idle();
    dbus_set(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    bus.ibus_cmd_valid = 1'b0;
    bus.ibus_cmd_pc    = 32'h0;
    bus.slv_ack        = '0;
    bus.slv_rdata      = '0;
  endtask

  // Single-cycle RAM write (caller guarantees the fabric is idle).
  task automatic ram_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    dbus_set(1'b1, 1'b1, a, d, sz);
    @(negedge clk);
    dbus_set(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.ibus_cmd_ready, bus.ibus_rsp_valid, bus.dbus_cmd_ready, bus.dbus_rsp_ready,
         bus.dbus_rsp_error, bus.bus_err, bus.slv_wr, dbg_state} !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {bus.ibus_cmd_ready,
               bus.ibus_rsp_valid, bus.dbus_cmd_ready, bus.dbus_rsp_ready,
               bus.dbus_rsp_error, bus.bus_err, bus.slv_wr, dbg_state});
    end
    n_checks++;
    if (bus.slv_cs !== 4'b0000 || bus.dbus_rsp_data !== 32'h0 || bus.ibus_rsp_inst !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_data: cs=%b rsp=%h inst=%h expected 0", bus.slv_cs,
               bus.dbus_rsp_data, bus.ibus_rsp_inst);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] wa [4] = '{32'h0, 32'h3, 32'h4, 32'h6};
    logic [31:0] wd [4] = '{32'h1122_3344, 32'hA5A5_A5A5, 32'h0, 32'hBEEF_BEEF};
    logic [1:0]  ws [4] = '{2'd2, 2'd0, 2'd2, 2'd1};
    logic [31:0] ra [3] = '{32'h0, 32'h4, 32'h0001_0000};
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dbus_set(1'b1, 1'b1, wa[i], wd[i], ws[i]);
      #1;
      n_checks++;
      if (bus.dbus_cmd_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL ram_wr_ready[%0d]: got %b expected 1", i, bus.dbus_cmd_ready);
      end
      @(negedge clk);
      dbus_set(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      #1;
      n_checks++;
      if (bus.dbus_rsp_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL ram_wr_norsp[%0d]: got %b expected 0", i, bus.dbus_rsp_ready);
      end
    end
    exp_q.push_back(32'hA522_3344);
    exp_q.push_back(32'hBEEF_0000);
    exp_q.push_back(32'hA522_3344);  // bit 16 is above the RAM index: aliases word 0
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dbus_set(1'b1, 1'b0, ra[i], 32'h0, 2'd2);
      #1;
      n_checks++;
      if (bus.dbus_cmd_ready !== 1'b1 || bus.dbus_rsp_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL ram_rd_accept[%0d]: ready=%b rsp=%b expected 1 0", i,
                 bus.dbus_cmd_ready, bus.dbus_rsp_ready);
      end
      @(negedge clk);
      dbus_set(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.dbus_rsp_ready !== 1'b1 || bus.dbus_rsp_data !== exp || bus.dbus_rsp_error !== 1'b0) begin
        n_errors++;
        $display("FAIL ram_rd_rsp[%0d]: rdy=%b data=%h err=%b expected 1 %h 0", i,
                 bus.dbus_rsp_ready, bus.dbus_rsp_data, bus.dbus_rsp_error, exp);
      end
    end
  endtask

  task automatic test_starve();
    int   grant_cyc = 0;
    logic dbus_ok = 1'b1;
    logic rsp17_ok = 1'b0;
    ram_write(32'h40, 32'h0BAD_F00D, 2'd2);
    @(negedge clk);
    dbus_set(1'b1, 1'b0, 32'h0, 32'h0, 2'd2);
    bus.ibus_cmd_valid = 1'b1;
    bus.ibus_cmd_pc    = 32'h40;
    for (int c = 1; c <= 17; c++) begin
      #1;
      if (c <= 15 && (bus.dbus_cmd_ready !== 1'b1 || bus.ibus_cmd_ready !== 1'b0)) dbus_ok = 1'b0;
      if (grant_cyc == 0 && bus.ibus_cmd_ready === 1'b1) grant_cyc = c;
      if (c == 16 && bus.dbus_cmd_ready !== 1'b0) dbus_ok = 1'b0;
      if (c == 17) rsp17_ok = (bus.ibus_rsp_valid === 1'b1) && (bus.ibus_rsp_inst === 32'h0BAD_F00D)
                              && (bus.dbus_cmd_ready === 1'b1) && (bus.dbus_rsp_ready === 1'b0);
      @(negedge clk);
    end
    drive_idle();
    n_checks++;
    if (grant_cyc != 16) begin
      n_errors++;
      $display("FAIL starve_grant_cycle: got %0d expected 16", grant_cyc);
    end
    n_checks++;
    if (dbus_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL starve_dbus_ready: got %b expected 1", dbus_ok);
    end
    n_checks++;
    if (rsp17_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL starve_ibus_rsp: got %b expected 1", rsp17_ok);
    end
  endtask

  task automatic test_slave_read();
    logic early = 1'b0;
    @(negedge clk);
    dbus_set(1'b1, 1'b0, 32'h0200_0204, 32'h0, 2'd2);
    #1;
    n_checks++;
    if (bus.slv_cs !== 4'b0100 || bus.slv_addr !== 8'h04 || bus.dbus_cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL slv_select: cs=%b addr=%h ready=%b expected 0100 04 0",
               bus.slv_cs, bus.slv_addr, bus.dbus_cmd_ready);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.slv_ack   = 4'b0010;  // a non-selected slave acking must be ignored
      bus.slv_rdata = {32'h0, 32'h0, 32'h1111_1111, 32'h0};
      #1;
      if (bus.dbus_cmd_ready !== 1'b0 || bus.slv_cs !== 4'b0100 || dbg_state !== 1'b1) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_errors++;
      $display("FAIL slv_wait: got early=%b expected 0", early);
    end
    @(negedge clk);
    bus.slv_ack   = 4'b0100;
    bus.slv_rdata = {32'h0, 32'hCAFE_0001, 32'h0, 32'h0};
    #1;
    n_checks++;
    if (bus.dbus_cmd_ready !== 1'b1 || bus.slv_cs !== 4'b0100) begin
      n_errors++;
      $display("FAIL slv_ack_ready: ready=%b cs=%b expected 1 0100", bus.dbus_cmd_ready, bus.slv_cs);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if (bus.dbus_rsp_ready !== 1'b1 || bus.dbus_rsp_data !== 32'hCAFE_0001 ||
        bus.dbus_rsp_error !== 1'b0 || bus.bus_err !== 1'b0 || dbg_state !== 1'b0) begin
      n_errors++;
      $display("FAIL slv_rsp: rdy=%b data=%h err=%b bus_err=%b st=%b expected 1 cafe0001 0 0 0",
               bus.dbus_rsp_ready, bus.dbus_rsp_data, bus.dbus_rsp_error, bus.bus_err, dbg_state);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.dbus_rsp_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL slv_rsp_once: got %b expected 0", bus.dbus_rsp_ready);
    end
  endtask

  task automatic test_slave_write();
    @(negedge clk);
    dbus_set(1'b1, 1'b1, 32'h0200_0001, 32'h5A5A_5A5A, 2'd0);
    bus.slv_ack = 4'b0001;  // zero-wait slave
    #1;
    n_checks++;
    if (bus.slv_cs !== 4'b0001 || bus.dbus_cmd_ready !== 1'b1 || bus.slv_wr !== 1'b1 ||
        bus.slv_be !== 4'b0010 || bus.slv_wdata !== 32'h5A5A_5A5A || bus.slv_addr !== 8'h01) begin
      n_errors++;
      $display("FAIL slv_write: cs=%b rdy=%b wr=%b be=%b wd=%h addr=%h expected 0001 1 1 0010 5a5a5a5a 01",
               bus.slv_cs, bus.dbus_cmd_ready, bus.slv_wr, bus.slv_be, bus.slv_wdata, bus.slv_addr);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if (bus.dbus_rsp_ready !== 1'b0 || bus.bus_err !== 1'b0 || dbg_state !== 1'b0) begin
      n_errors++;
      $display("FAIL slv_write_after: rsp=%b bus_err=%b st=%b expected 0 0 0",
               bus.dbus_rsp_ready, bus.bus_err, dbg_state);
    end
  endtask

  task automatic test_timeout();
    int c = 0;
    @(negedge clk);
    dbus_set(1'b1, 1'b0, 32'h0200_0100, 32'h0, 2'd2);
    #1;
    n_checks++;
    if (bus.slv_cs !== 4'b0010) begin
      n_errors++;
      $display("FAIL tmo_select: got %b expected 0010", bus.slv_cs);
    end
    while (bus.dbus_cmd_ready !== 1'b1 && c < 400) begin
      @(negedge clk);
      #1;
      c++;
    end
    n_checks++;
    if (c != 255) begin
      n_errors++;
      $display("FAIL tmo_cycle: got %0d expected 255", c);
    end
    n_checks++;
    if (bus.slv_cs !== 4'b0000) begin
      n_errors++;
      $display("FAIL tmo_cs_drop: got %b expected 0000", bus.slv_cs);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if (bus.dbus_rsp_ready !== 1'b1 || bus.dbus_rsp_data !== 32'hDEAD_BEEF ||
        bus.dbus_rsp_error !== 1'b1 || bus.bus_err !== 1'b1) begin
      n_errors++;
      $display("FAIL tmo_rsp: rdy=%b data=%h err=%b bus_err=%b expected 1 deadbeef 1 1",
               bus.dbus_rsp_ready, bus.dbus_rsp_data, bus.dbus_rsp_error, bus.bus_err);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.bus_err !== 1'b0 || bus.dbus_rsp_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_pulse: bus_err=%b rsp=%b expected 0 0", bus.bus_err, bus.dbus_rsp_ready);
    end
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    dbus_set(1'b1, 1'b0, 32'h0200_0F00, 32'h0, 2'd2);
    #1;
    n_checks++;
    if (bus.dbus_cmd_ready !== 1'b1 || bus.slv_cs !== 4'b0000) begin
      n_errors++;
      $display("FAIL unmap_rd_ready: ready=%b cs=%b expected 1 0000", bus.dbus_cmd_ready, bus.slv_cs);
    end
    @(negedge clk);
    dbus_set(1'b1, 1'b1, 32'h0200_0F00, 32'h1234_5678, 2'd2);
    #1;
    n_checks++;
    if (bus.dbus_rsp_ready !== 1'b1 || bus.dbus_rsp_data !== 32'h0 ||
        bus.dbus_rsp_error !== 1'b1 || bus.bus_err !== 1'b1 || bus.dbus_cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL unmap_rd_rsp: rdy=%b data=%h err=%b bus_err=%b wr_ready=%b expected 1 0 1 1 1",
               bus.dbus_rsp_ready, bus.dbus_rsp_data, bus.dbus_rsp_error, bus.bus_err,
               bus.dbus_cmd_ready);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if (bus.dbus_rsp_ready !== 1'b0 || bus.bus_err !== 1'b1) begin
      n_errors++;
      $display("FAIL unmap_wr: rsp=%b bus_err=%b expected 0 1", bus.dbus_rsp_ready, bus.bus_err);
    end
  endtask

  task automatic test_reset_in_slv();
    @(negedge clk);
    dbus_set(1'b1, 1'b0, 32'h0200_0300, 32'h0, 2'd2);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.slv_cs !== 4'b1000 || dbg_state !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_slv_pending: cs=%b st=%b expected 1000 1", bus.slv_cs, dbg_state);
    end
    @(negedge clk);
    drive_idle();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_checks++;
    if (bus.slv_cs !== 4'b0000 || bus.dbus_rsp_ready !== 1'b0 || dbg_state !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_slv_clear: cs=%b rsp=%b st=%b expected 0000 0 0",
               bus.slv_cs, bus.dbus_rsp_ready, dbg_state);
    end
    @(negedge clk);
    dbus_set(1'b1, 1'b0, 32'h0, 32'h0, 2'd2);
    #1;
    n_checks++;
    if (bus.dbus_cmd_ready !== 1'b1 || bus.dbus_rsp_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_ram_accept: ready=%b rsp=%b expected 1 0", bus.dbus_cmd_ready, bus.dbus_rsp_ready);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if (bus.dbus_rsp_ready !== 1'b1 || bus.dbus_rsp_data !== 32'hA522_3344 || bus.dbus_rsp_error !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_ram_rsp: rdy=%b data=%h err=%b expected 1 a5223344 0",
               bus.dbus_rsp_ready, bus.dbus_rsp_data, bus.dbus_rsp_error);
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    drive_idle();
    resetn = 1'b0;
    test_reset();
    test_ram();
    test_starve();
    test_slave_read();
    test_slave_write();
    test_timeout();
    test_unmapped();
    test_reset_in_slv();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
